d_mem_ctrl: RTL and testbench

- Next-generation data memory for the processor datapath.
- Replaces the single-cycle word-only data memory with a handshaked, multi-cycle memory:
  - sub-word loads and stores (byte, halfword, word) with optional sign extension;
  - byte-lane write merging;
  - configurable wait states;
  - misalignment and out-of-range error reporting.
- Sits between the MEM stage and backing storage; storage is an internal word array with per-byte write.

---
 rtl/d_mem_pkg.sv | 28 ++
 rtl/d_mem_lane.sv | 60 ++++++
 rtl/d_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_d_mem_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/d_mem_pkg.sv
// Shared encodings and helpers for the data memory controller.
package d_mem_pkg;

    // Access size encodings; 2'b11 is reserved and rejected as illegal
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Little-endian byte lanes in a 32-bit word
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // True when the low address bits do not match the natural alignment of the size
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/d_mem_lane.sv
// Byte-lane steering: store-side byte enables / replicated write data,
// load-side sub-word extraction with sign or zero extension.
module d_mem_lane
    import d_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lo,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: the write data is replicated across lanes so the byte enables alone pick the target bytes
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load side: pick the addressed byte/half, then extend to a full word
    always_comb begin
        w_byte = i_rword[7:0];
        case (i_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_lo[1] ? i_rword[31:16] : i_rword[15:0];
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_sign_ext & w_half[15]}}, w_half};
            default: o_rdata = i_rword;
        endcase
    end

endmodule

// File: rtl/d_mem_ctrl.sv
// Handshaked multi-cycle data memory: sub-word access, byte-lane write merge,
// configurable wait states, misalignment and range errors. Clocked on the falling edge.
module d_mem_ctrl
    import d_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  WrEn,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

    // Control registers
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_ready;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_data_out;

    // Request registers, captured on acceptance
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_sext;
    logic [IDX_W-1:0]      r_idx;
    logic [1:0]            r_lo;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_bad;

    // Backing storage; intentionally not cleared by reset
    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] w_widx_ext;
    logic                  w_illegal;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [DATA_WIDTH-1:0] w_rword;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Legality is judged on the live request so an illegal one can skip straight to RESP
    assign w_widx_ext = {2'b00, adr[ADDR_WIDTH-1:2]};
    assign w_illegal  = (size == 2'b11) || is_misaligned(size, adr[1:0]) ||
                        (w_widx_ext >= DEPTH_A);

    assign w_rword = r_mem[r_idx];

    d_mem_lane u_lane (
        .i_size     (r_size),
        .i_lo       (r_lo),
        .i_sign_ext (r_sext),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata)
    );

    // FSM: accept in IDLE, count wait states, access storage, then pulse ready/err from RESP
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we    <= WrEn;
                        r_size  <= size;
                        r_sext  <= sign_ext;
                        r_idx   <= adr[IDX_W+1:2];
                        r_lo    <= adr[1:0];
                        r_wdata <= data_in;
                        if (w_illegal) begin
                            r_bad   <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_bad   <= 1'b0;
                            r_cnt   <= 4'(WAIT_STATES);
                            r_state <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_data_out <= w_rdata;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_ready <= 1'b1;
                    r_err   <= r_bad;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Byte-enabled store; gated by rst_n so a reset landing on ACCESS aborts the write
    always_ff @(negedge clk) begin
        if (rst_n && (r_state == ACCESS) && r_we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_be[l]) begin
                    r_mem[r_idx][8*l +: 8] <= w_wdata_sh[8*l +: 8];
                end
            end
        end
    end

    assign data_out = r_data_out;
    assign ready    = r_ready;
    assign err      = r_err;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Directed bench for d_mem_ctrl: three instances with WAIT_STATES = 1, 3, 0.
module tb_d_mem_ctrl;
    import d_mem_pkg::*;

    logic        clk;
    logic        rstn_a [3];
    logic        req_a  [3];
    logic        we_a   [3];
    logic [1:0]  sz_a   [3];
    logic        sx_a   [3];
    logic [31:0] adr_a  [3];
    logic [31:0] din_a  [3];
    logic [31:0] dout_a [3];
    logic        rdy_a  [3];
    logic        err_a  [3];

    int tests = 0;
    int fails = 0;

    d_mem_ctrl #(.WAIT_STATES(1)) u0 (
        .clk(clk), .rst_n(rstn_a[0]), .req(req_a[0]), .WrEn(we_a[0]), .size(sz_a[0]),
        .sign_ext(sx_a[0]), .adr(adr_a[0]), .data_in(din_a[0]), .data_out(dout_a[0]),
        .ready(rdy_a[0]), .err(err_a[0]));
    d_mem_ctrl #(.WAIT_STATES(3)) u1 (
        .clk(clk), .rst_n(rstn_a[1]), .req(req_a[1]), .WrEn(we_a[1]), .size(sz_a[1]),
        .sign_ext(sx_a[1]), .adr(adr_a[1]), .data_in(din_a[1]), .data_out(dout_a[1]),
        .ready(rdy_a[1]), .err(err_a[1]));
    d_mem_ctrl #(.WAIT_STATES(0)) u2 (
        .clk(clk), .rst_n(rstn_a[2]), .req(req_a[2]), .WrEn(we_a[2]), .size(sz_a[2]),
        .sign_ext(sx_a[2]), .adr(adr_a[2]), .data_in(din_a[2]), .data_out(dout_a[2]),
        .ready(rdy_a[2]), .err(err_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] adr;
        logic [31:0] din;
        int          lat;
        logic        e;
        logic [31:0] dout;
    } vec_t;

    vec_t tv [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        req_a[k] = 1'b1;
        we_a[k]  = we;
        sz_a[k]  = sz;
        sx_a[k]  = sx;
        adr_a[k] = a;
        din_a[k] = d;
    endtask

    // One complete access: drive on a rising edge, wait for ready, check latency/err/data and pulse width
    task automatic do_access(input int k, input logic we, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                             input logic exp_err, input logic [31:0] exp_do, input string nm);
        int  c;
        bit  got;
        got = 1'b0;
        @(posedge clk);
        drive(k, we, sz, sx, a, d);
        for (c = 1; c <= 40; c++) begin
            @(posedge clk);
            if (rdy_a[k] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        req_a[k] = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no ready, expected ready within 40 cycles", nm);
        end else begin
            chk({nm, "_lat"}, 32'(c - 1), 32'(exp_lat));
            chk({nm, "_err"}, {31'd0, err_a[k]}, {31'd0, exp_err});
            chk({nm, "_dout"}, dout_a[k], exp_do);
            @(posedge clk);
            chk({nm, "_pulse"}, {30'd0, rdy_a[k], err_a[k]}, 32'd0);
        end
    endtask

    initial begin
        int  cyc;
        int  last;
        int  idx;
        bit  saw;
        vec_t cs [4];

        for (int k = 0; k < 3; k++) begin
            rstn_a[k] = 1'b0; req_a[k] = 1'b0; we_a[k] = 1'b0; sz_a[k] = 2'b00;
            sx_a[k] = 1'b0; adr_a[k] = '0; din_a[k] = '0;
        end

        //            we    sz       sx    adr           din            lat e     dout
        tv[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0000};
        tv[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0000_0000, 3, 1'b0, 32'hDEAD_BEEF};
        tv[2]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_0011, 32'hFFFF_FF55, 3, 1'b0, 32'hDEAD_BEEF};
        tv[3]  = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0012, 32'hABCD_1234, 3, 1'b0, 32'hDEAD_BEEF};
        tv[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0000_0000, 3, 1'b0, 32'h1234_55EF};
        tv[5]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0000_0000, 3, 1'b0, 32'h0000_0012};
        tv[6]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_0010, 32'h0000_0080, 3, 1'b0, 32'h0000_0012};
        tv[7]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_0010, 32'h0000_0000, 3, 1'b0, 32'hFFFF_FF80};
        tv[8]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_0010, 32'h0000_0000, 3, 1'b0, 32'h0000_0080};
        tv[9]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_0012, 32'h0000_0000, 3, 1'b0, 32'h0000_1234};
        tv[10] = '{1'b0, SZ_HALF, 1'b1, 32'h0000_0010, 32'h0000_0000, 3, 1'b0, 32'h0000_5580};
        tv[11] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0012, 32'h0000_BEEF, 3, 1'b0, 32'h0000_5580};
        tv[12] = '{1'b0, SZ_HALF, 1'b1, 32'h0000_0012, 32'h0000_0000, 3, 1'b0, 32'hFFFF_BEEF};
        tv[13] = '{1'b0, SZ_HALF, 1'b0, 32'h0000_0012, 32'h0000_0000, 3, 1'b0, 32'h0000_BEEF};
        tv[14] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0002, 32'h0000_0000, 1, 1'b1, 32'h0000_BEEF};
        tv[15] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_BEEF};
        tv[16] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0011, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_BEEF};
        tv[17] = '{1'b0, 2'b11,   1'b0, 32'h0000_0010, 32'h0000_0000, 1, 1'b1, 32'h0000_BEEF};
        tv[18] = '{1'b1, SZ_WORD, 1'b0, 32'h0000_1000, 32'h0BAD_0BAD, 1, 1'b1, 32'h0000_BEEF};
        tv[19] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_1000, 32'h0000_0000, 1, 1'b1, 32'h0000_BEEF};
        tv[20] = '{1'b0, SZ_HALF, 1'b0, 32'h0000_0013, 32'h0000_0000, 1, 1'b1, 32'h0000_BEEF};
        tv[21] = '{1'b1, SZ_WORD, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 3, 1'b0, 32'h0000_BEEF};
        tv[22] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 3, 1'b0, 32'hCAFE_F00D};
        tv[23] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0000_0000, 3, 1'b0, 32'hBEEF_5580};

        // Reset held over two falling edges, then idle with req low
        repeat (3) @(posedge clk);
        for (int k = 0; k < 3; k++) rstn_a[k] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst_u%0d_c%0d_rdy_err", k, n), {30'd0, rdy_a[k], err_a[k]}, 32'd0);
                chk($sformatf("rst_u%0d_c%0d_dout", k, n), dout_a[k], 32'd0);
            end
        end

        // Table-driven accesses on the single-wait-state instance
        for (int i = 0; i < 24; i++) begin
            do_access(0, tv[i].we, tv[i].sz, tv[i].sx, tv[i].adr, tv[i].din,
                      tv[i].lat, tv[i].e, tv[i].dout, $sformatf("vec%0d", i));
        end

        // Reset during WAIT (3 wait states): aborted store must not land, no ready
        do_access(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344, 5, 1'b0, 32'h0, "u1_prestore");
        @(posedge clk);
        drive(1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hAAAA_AAAA);
        @(posedge clk);
        @(posedge clk);
        rstn_a[1] = 1'b0;
        req_a[1]  = 1'b0;
        @(posedge clk);
        rstn_a[1] = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk);
            if (rdy_a[1] !== 1'b0) saw = 1'b1;
        end
        chk("u1_abort_no_ready", {31'd0, saw}, 32'd0);
        chk("u1_abort_dout", dout_a[1], 32'd0);
        do_access(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 5, 1'b0, 32'h1122_3344, "u1_reload");

        // Zero wait states with req held high across back-to-back accesses
        cs[0] = '{1'b1, SZ_WORD, 1'b0, 32'h40, 32'h0BAD_F00D, 3, 1'b0, 32'h0000_0000};
        cs[1] = '{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0000_0000, 3, 1'b0, 32'h0BAD_F00D};
        cs[2] = '{1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h0000_0077, 3, 1'b0, 32'h0BAD_F00D};
        cs[3] = '{1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0000_0000, 3, 1'b0, 32'h0BAD_770D};
        @(posedge clk);
        drive(2, cs[0].we, cs[0].sz, cs[0].sx, cs[0].adr, cs[0].din);
        cyc  = 0;
        last = 0;
        idx  = 0;
        while (idx < 4 && cyc < 60) begin
            @(posedge clk);
            cyc++;
            if (rdy_a[2] === 1'b1) begin
                chk($sformatf("cont%0d_gap", idx), 32'(cyc - last), 32'(cs[idx].lat));
                chk($sformatf("cont%0d_err", idx), {31'd0, err_a[2]}, 32'd0);
                chk($sformatf("cont%0d_dout", idx), dout_a[2], cs[idx].dout);
                last = cyc;
                idx++;
                if (idx < 4) drive(2, cs[idx].we, cs[idx].sz, cs[idx].sx, cs[idx].adr, cs[idx].din);
                else req_a[2] = 1'b0;
            end
        end
        if (idx < 4) begin
            tests++;
            fails++;
            $display("FAIL cont_timeout: got %0d ready pulses, expected 4", idx);
            req_a[2] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
